mix_columns_iter: RTL and testbench
===================================

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have port in_valid, input, 1 bit: the istate value is valid.
REQ-004 The module SHALL have port in_ready, output, 1 bit: the block accepts an istate value this cycle.
REQ-005 The module SHALL have port istate, input, 128 bits: the AES state to transform.
REQ-006 The module SHALL have port out_valid, output, 1 bit: ostate holds a finished result.
REQ-007 The module SHALL have port out_ready, input, 1 bit: the consumer accepts ostate this cycle.
REQ-008 The module SHALL have port ostate, output, 128 bits: the MixColumns result.
REQ-009 The module SHALL have port busy, output, 1 bit: high in state BUSY.

Function
REQ-010 The state packing SHALL be: column c (0..3) = bits [127-32c -: 32]; row 0 of the column is the most significant byte.
REQ-011 The block SHALL compute forward AES MixColumns per column: matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02} over GF(2^8).
REQ-012 xtime SHALL be a left shift by 1, XORed with 8'h1b when the input MSB = 1; multiply by 03 SHALL equal xtime(x) ^ x; all results SHALL be 8 bits.
REQ-013 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, out_valid SHALL be 1 only in DONE, and busy SHALL be 1 only in BUSY.
REQ-015 IDLE -> BUSY SHALL occur on in_valid && in_ready; the internal 128-bit register SHALL load istate and the 2-bit column counter SHALL be set to 0.
REQ-016 In BUSY, one column per cycle SHALL be processed in order c = 0, 1, 2, 3, overwriting that column in place; the counter SHALL increment, and after c = 3 the FSM SHALL go to DONE (no wrap to 0 while in BUSY).
REQ-017 Latency: for a handshake at edge T, out_valid SHALL first be 1 after edge T+4 (4 BUSY cycles).
REQ-018 In DONE, ostate and out_valid SHALL stay stable until out_valid && out_ready; on that edge the FSM SHALL go to IDLE.
REQ-019 in_valid and istate SHALL be ignored outside IDLE; no new input SHALL be accepted in the same cycle as the output handshake (minimum 6 cycles per block).
REQ-020 ostate SHALL be driven from the internal register; its value SHALL be meaningful only while out_valid = 1.
REQ-021 out_ready while not in DONE SHALL have no effect.

Reset
REQ-022 On rst = 1 at a rising clk edge, the FSM SHALL enter IDLE, the counter SHALL clear to 0 and the internal register (ostate) SHALL clear to 128'h0, with outputs after that edge in_ready = 1, out_valid = 0 and busy = 0.
REQ-023 Reset SHALL take priority over every other event, including mid-BUSY and during a DONE output handshake; any in-flight block SHALL be discarded with no out_valid pulse.

Structure
REQ-024 A shared package aes_pkg SHALL hold the reduction constant 8'h1b, the FSM state enumeration and a column-width constant of 32.
REQ-025 A combinational sub-module mix_column_word SHALL hold the 32-bit in / 32-bit out single-column transform, with one instance muxed by the counter.

Verification
REQ-026 The bench SHALL apply istate = db135345_f20a225c_01010101_c6c6c6c6 with out_ready = 1 and SHALL require ostate = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 with out_valid asserted exactly 4 cycles after acceptance.
REQ-027 The bench SHALL apply istate = d4d4d4d5_2d26314c_00000000_ffffffff and SHALL require ostate = d5d5d7d6_4d7ebdf8_00000000_ffffffff.
REQ-028 The bench SHALL hold out_ready = 0 for 10 cycles in DONE and SHALL require ostate and out_valid stable, in_ready = 0, and a changing istate/in_valid to be ignored; after out_ready = 1 it SHALL require IDLE on the next cycle.
REQ-029 The bench SHALL assert rst during the BUSY cycle with c = 2 and SHALL require in_ready = 1, out_valid = 0, busy = 0 and ostate = 0 on the next cycle, followed by a correct fresh transform afterwards.
REQ-030 The bench SHALL run 1000 random back-to-back blocks with random out_ready stalls and SHALL require every result to match a reference model, with in order, no loss and no duplication.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) reduction constant, column width, FSM
// state encoding and the byte-level multiply helpers used by MixColumns.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int         COL_W    = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward MixColumns on one 32-bit column, row 0 in the
// most significant byte.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    output logic [COL_W-1:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col = {xtime(w_a0) ^ mul3(w_a1) ^ w_a2        ^ w_a3,
                    w_a0        ^ xtime(w_a1) ^ mul3(w_a2) ^ w_a3,
                    w_a0        ^ w_a1        ^ xtime(w_a2) ^ mul3(w_a3),
                    mul3(w_a0)  ^ w_a1        ^ w_a2        ^ xtime(w_a3)};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per cycle through a single shared
// column transform, result held until the consumer takes it.
module mix_columns_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] istate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ostate,
    output logic         busy
);

    state_t             r_state;
    logic [1:0]         r_cnt;
    logic [127:0]       r_data;
    logic [COL_W-1:0]   w_col_in;
    logic [COL_W-1:0]   w_col_out;
    logic [127:0]       w_data_next;

    // A transfer happens on a rising edge where valid && ready are both high;
    // valid must hold its data until that edge, ready never depends on valid.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_BUSY);
    assign ostate    = r_data;

    always_comb begin
        w_col_in = r_data[127:96];
        case (r_cnt)
            2'd0: w_col_in = r_data[127:96];
            2'd1: w_col_in = r_data[95:64];
            2'd2: w_col_in = r_data[63:32];
            2'd3: w_col_in = r_data[31:0];
            default: w_col_in = r_data[127:96];
        endcase
    end

    mix_column_word u_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_comb begin
        w_data_next = r_data;
        case (r_cnt)
            2'd0: w_data_next[127:96] = w_col_out;
            2'd1: w_data_next[95:64]  = w_col_out;
            2'd2: w_data_next[63:32]  = w_col_out;
            2'd3: w_data_next[31:0]   = w_col_out;
            default: w_data_next = r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_data  <= 128'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= istate;
                        r_cnt   <= 2'd0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_data <= w_data_next;
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: directed vectors, stall/reset
// corner cases and a randomized scoreboard run against a GF(2^8) model.
module tb_mix_columns_iter;

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam int N_BLOCKS = 1000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] istate;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ostate;
    logic         busy;

    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    bit rnd_phase = 0;
    bit drv_done  = 0;

    mix_columns_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .istate    (istate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ostate    (ostate),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] mc_ref(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            r[103 - 32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard: push on input handshake, pop/compare on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(mc_ref(istate));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 128'd1, 128'd0);
                end else begin
                    check("sb_ostate", ostate, exp_q.pop_front());
                end
                if (rnd_phase) n_out++;
            end
        end
    end

    // driver tasks
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_block(input logic [127:0] d);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        istate   = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        istate   = rand128();
    endtask

    task automatic wait_out_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("out_valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        istate    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_ostate",    ostate,              128'd0);

        // first directed vector, latency of exactly 4 cycles
        send_block(V1_IN);
        wait_out_valid(lat);
        check("v1_latency", 128'(lat), 128'd4);
        check("v1_ostate", ostate, V1_OUT);
        idle_cycles(2);

        // second vector held in DONE for 10 cycles with input noise
        out_ready = 1'b0;
        send_block(V2_IN);
        wait_out_valid(lat);
        check("v2_latency", 128'(lat), 128'd4);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            istate   = rand128();
            @(negedge clk);
            check("stall_ostate",    ostate,              V2_OUT);
            check("stall_out_valid", {127'd0, out_valid}, 128'd1);
            check("stall_in_ready",  {127'd0, in_ready},  128'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        istate    = rand128();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_in_ready",  {127'd0, in_ready},  128'd1);
        check("post_hs_out_valid", {127'd0, out_valid}, 128'd0);
        check("post_hs_busy",      {127'd0, busy},      128'd0);
        in_valid = 1'b0;
        idle_cycles(2);

        // reset while processing column 2
        send_block(V1_IN);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_busy",      {127'd0, busy},      128'd0);
        check("mid_rst_ostate",    ostate,              128'd0);
        saw_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        check("no_valid_after_rst", {127'd0, saw_valid}, 128'd0);
        send_block(V2_IN);
        wait_out_valid(lat);
        check("post_rst_ostate", ostate, V2_OUT);
        idle_cycles(2);

        // randomized back-to-back blocks with consumer stalls
        rnd_phase = 1;
        fork
            begin
                for (int i = 0; i < N_BLOCKS; i++) send_block(rand128());
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        idle_cycles(2);
        check("drain_empty", 128'(exp_q.size()), 128'd0);
        check("rnd_out_count", 128'(n_out), 128'(N_BLOCKS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
